// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its word assembler.
package loader_pkg;

   localparam int unsigned ADDR_W_DEFAULT    = 11;
   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

   // Frame fields: sync, addr lo/hi, count lo/hi, 4*count data bytes, optional checksum.
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned BYTE_IDX_W = 2;

   typedef enum logic [2:0] {
      StSync,
      StAddrLo,
      StAddrHi,
      StCntLo,
      StCntHi,
      StData,
      StWrite,
      StCheck
   } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs little-endian data bytes into 32-bit words; keeps the running XOR of all data
// bytes when LOADER_CHECKSUM_EN is defined.
module loader_word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
`ifdef LOADER_CHECKSUM_EN
   output logic [7:0]  chk,
`endif
   output logic        word_ready
);

   logic [BYTE_IDX_W-1:0] idx_q;

   assign word_ready = byte_valid && (idx_q == BYTE_IDX_W'(WORD_BYTES - 1));

   // Shifting in from the top leaves the first byte of a word in bits [7:0].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         word  <= '0;
      end else if (clear) begin
         idx_q <= '0;
      end else if (byte_valid) begin
         idx_q <= idx_q + BYTE_IDX_W'(1);
         word  <= {byte_in, word[31:8]};
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk <= '0;
      end else if (clear) begin
         chk <= '0;
      end else if (byte_valid) begin
         chk <= chk ^ byte_in;
      end
   end
`endif

endmodule

// File: rtl/program_loader.sv
// Program loader: turns a framed host byte stream into instruction-memory writes and
// releases the CPU at start_pc. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W-1:0] start_pc,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   loader_state_t     state;
   logic [7:0]        addr_lo_q;
   logic [7:0]        cnt_lo_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] base_addr_q;
   logic              accept;
   logic              sync_acc;
   logic              data_acc;
   logic              word_ready;
   logic [ADDR_W-1:0] frame_addr;
   logic [CNT_W-1:0]  frame_cnt;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        chk;
`endif

   assign accept     = in_valid && in_ready;
   assign sync_acc   = accept && (state == StSync) && (in_data == SYNC_BYTE);
   assign data_acc   = accept && (state == StData);
   assign frame_addr = ADDR_W'({in_data, addr_lo_q});
   assign frame_cnt  = {in_data, cnt_lo_q};

   loader_word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (sync_acc),
      .byte_valid (data_acc),
      .byte_in    (in_data),
      .word       (mem_wdata),
`ifdef LOADER_CHECKSUM_EN
      .chk        (chk),
`endif
      .word_ready (word_ready)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StSync;
         in_ready    <= 1'b1;
         mem_wren    <= 1'b0;
         mem_addr    <= '0;
         start_pc    <= '0;
         cpu_hold    <= 1'b1;
         done        <= 1'b0;
         error       <= 1'b0;
         addr_lo_q   <= '0;
         cnt_lo_q    <= '0;
         cnt_q       <= '0;
         base_addr_q <= '0;
      end else begin
         mem_wren <= 1'b0;
         unique case (state)
            StSync: begin
               if (sync_acc) begin
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  state    <= StAddrLo;
               end
            end
            StAddrLo: begin
               if (accept) begin
                  addr_lo_q <= in_data;
                  state     <= StAddrHi;
               end
            end
            StAddrHi: begin
               if (accept) begin
                  base_addr_q <= frame_addr;
                  mem_addr    <= frame_addr;
                  state       <= StCntLo;
               end
            end
            StCntLo: begin
               if (accept) begin
                  cnt_lo_q <= in_data;
                  state    <= StCntHi;
               end
            end
            StCntHi: begin
               if (accept) begin
                  cnt_q <= frame_cnt;
                  if (frame_cnt == '0) begin
`ifdef LOADER_CHECKSUM_EN
                     state <= StCheck;
`else
                     start_pc <= base_addr_q;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     state    <= StSync;
`endif
                  end else begin
                     state <= StData;
                  end
               end
            end
            StData: begin
               // Stall the stream for one cycle while the completed word is written.
               if (word_ready) begin
                  in_ready <= 1'b0;
                  mem_wren <= 1'b1;
                  state    <= StWrite;
               end
            end
            StWrite: begin
               in_ready <= 1'b1;
               mem_addr <= mem_addr + ADDR_W'(1);
               cnt_q    <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                  state <= StCheck;
`else
                  start_pc <= base_addr_q;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  state    <= StSync;
`endif
               end else begin
                  state <= StData;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
               if (accept) begin
                  if (in_data == chk) begin
                     start_pc <= base_addr_q;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     error <= 1'b1;
                  end
                  state <= StSync;
               end
            end
`endif
            default: state <= StSync;
         endcase
      end
   end

endmodule
